// File: rtl/transaccion_rr_scheduler.sv
// Round-robin scheduler moving words from 4 input FIFOs to 4 output FIFOs (dest = word MSBs).
// Optional push statistics are enabled by defining TRANSACCION_STATS_EN.
module transaccion_rr_scheduler #(
    parameter int FIFO_WORD_SIZE = 10
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_init,
    input  logic [3:0]                  i_fifo_in_empty,
    input  logic [4*FIFO_WORD_SIZE-1:0] i_fifo_in_data,
    input  logic [3:0]                  i_fifo_out_almost_full,
    output logic [3:0]                  o_pop_in,
    output logic [3:0]                  o_push_out,
    output logic [FIFO_WORD_SIZE-1:0]   o_data_out,
    output logic                        o_idle,
    output logic [1:0]                  o_state
`ifdef TRANSACCION_STATS_EN
    ,
    input  logic                        i_stat_req,
    input  logic [1:0]                  i_stat_idx,
    output logic [4:0]                  o_stat_data,
    output logic                        o_stat_valid
`endif
);

    localparam int W = FIFO_WORD_SIZE;

    typedef enum logic [1:0] {
        ST_RESET  = 2'b00,
        ST_INIT   = 2'b01,
        ST_IDLE   = 2'b10,
        ST_ACTIVE = 2'b11
    } state_t;

    state_t         r_state;
    logic           r_idle;
    logic [1:0]     r_rr_ptr;
    logic [3:0]     r_push;
    logic [W-1:0]   r_data;

    logic [1:0]     w_dest [4];
    logic [3:0]     w_eligible;
    logic           w_pop_allowed;
    logic           w_grant_valid;
    logic [1:0]     w_grant_idx;
    logic [W-1:0]   w_grant_word;
    logic [1:0]     w_grant_dest;

    // An input is skipped only if its own destination is almost full, so no head-of-line blocking.
    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < 4; i++) begin
            w_dest[i]     = i_fifo_in_data[i*W + W-2 +: 2];
            w_eligible[i] = !i_fifo_in_empty[i] && !i_fifo_out_almost_full[w_dest[i]];
        end
    end

    assign w_pop_allowed = !i_reset && !i_init && (r_state == ST_IDLE || r_state == ST_ACTIVE);

    always_comb begin
        logic [1:0] v_cand;
        w_grant_valid = 1'b0;
        w_grant_idx   = r_rr_ptr;
        v_cand        = r_rr_ptr;
        for (int k = 1; k <= 4; k++) begin
            v_cand = r_rr_ptr + 2'(k);
            if (!w_grant_valid && w_pop_allowed && w_eligible[v_cand]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = v_cand;
            end
        end
    end

    assign w_grant_word = i_fifo_in_data[w_grant_idx*W +: W];
    assign w_grant_dest = w_dest[w_grant_idx];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= ST_RESET;
            r_idle   <= 1'b0;
            r_rr_ptr <= 2'd3;
            r_push   <= '0;
            r_data   <= '0;
        end else begin
            r_push <= w_grant_valid ? (4'b0001 << w_grant_dest) : 4'b0000;
            if (w_grant_valid) begin
                r_data   <= w_grant_word;
                r_rr_ptr <= w_grant_idx;
            end
            // init overrides every state; a push already registered still goes out
            if (i_init) begin
                r_state <= ST_INIT;
                r_idle  <= 1'b0;
            end else begin
                case (r_state)
                    ST_RESET, ST_INIT: begin
                        r_state <= ST_IDLE;
                        r_idle  <= 1'b1;
                    end
                    ST_IDLE: begin
                        if (w_grant_valid) begin
                            r_state <= ST_ACTIVE;
                            r_idle  <= 1'b0;
                        end
                    end
                    ST_ACTIVE: begin
                        if (!w_grant_valid && r_push == 4'b0000) begin
                            r_state <= ST_IDLE;
                            r_idle  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_RESET;
                        r_idle  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_pop_in   = w_grant_valid ? (4'b0001 << w_grant_idx) : 4'b0000;
    assign o_push_out = r_push;
    assign o_data_out = r_data;
    assign o_idle     = r_idle;
    assign o_state    = r_state;

`ifdef TRANSACCION_STATS_EN
    logic [4:0] r_count [4];
    logic [4:0] r_stat_data;
    logic       r_stat_valid;

    // Per-output push counters saturate at 31 and are held clear during configuration.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_init) begin
            for (int j = 0; j < 4; j++) begin
                r_count[j] <= '0;
            end
        end else begin
            for (int j = 0; j < 4; j++) begin
                if (r_push[j] && r_count[j] != 5'd31) begin
                    r_count[j] <= r_count[j] + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stat_valid <= 1'b0;
            r_stat_data  <= '0;
        end else begin
            r_stat_valid <= i_stat_req;
            r_stat_data  <= i_stat_req ? r_count[i_stat_idx] : 5'd0;
        end
    end

    assign o_stat_data  = r_stat_data;
    assign o_stat_valid = r_stat_valid;
`endif

endmodule
